// File: rtl/csr_hpm.sv
// csr_hpm: machine-mode CSR file with synchronised interrupt lines, mcountinhibit
// and NUM_HPM event-driven hardware performance counters.
module csr_hpm #(
    parameter int unsigned NUM_HPM     = 4,
    parameter int unsigned NUM_EVENTS  = 8,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // decode-side read port
    input  logic [11:0]           read_address,
    output logic [31:0]           read_data,
    output logic                  readable,
    output logic                  writeable,
    // writeback-side write port and strobes
    input  logic                  write_enable,
    input  logic [11:0]           write_address,
    input  logic [31:0]           write_data,
    input  logic                  retired,
    input  logic                  traped,
    input  logic                  mret,
    input  logic [31:0]           ecp,
    input  logic [3:0]            trap_cause,
    input  logic                  interupt,
    // raw interrupt lines and event strobes
    input  logic                  ext_irq,
    input  logic                  timer_irq,
    input  logic                  soft_irq,
    input  logic [NUM_EVENTS-1:0] events,
    // enabled pending interrupts and vectors
    output logic                  eip,
    output logic                  tip,
    output logic                  sip,
    output logic [31:0]           trap_vector,
    output logic [31:0]           mret_vector
);

    // Keep arrays non-empty when no HPM counters are implemented.
    localparam int unsigned HpmSlots = (NUM_HPM > 0) ? NUM_HPM : 1;
    // Implemented mcountinhibit bits: CY, IR and one per HPM counter.
    localparam logic [31:0] InhibitMask =
        32'h0000_0005 | (((32'd1 << NUM_HPM) - 32'd1) << 3);

    // mstatus / mie / mip fields
    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic        meie_q, meie_d, mtie_q, mtie_d, msie_q, msie_d;
    logic        meip_q, mtip_q, msip_q;
    // trap state
    logic [29:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [29:0] mepc_q, mepc_d;
    logic        mcause_int_q, mcause_int_d;
    logic [3:0]  mcause_code_q, mcause_code_d;
    // counters
    logic [31:0] inhibit_q, inhibit_d;
    logic [63:0] cycle_q, cycle_d;
    logic [63:0] instret_q, instret_d;
    logic [63:0] hpm_q [HpmSlots];
    logic [63:0] hpm_d [HpmSlots];
    logic [7:0]  sel_q [HpmSlots];
    logic [7:0]  sel_d [HpmSlots];

    // Low two bits of the saved PC are never stored.
    logic unused_ecp_lsbs;
    assign unused_ecp_lsbs = ^ecp[1:0];

    // One 64-bit counter step: a write to a half beats that half's increment; a low
    // write suppresses the carry, a high write discards it.
    function automatic logic [63:0] count_next(input logic [63:0] cur, input logic inc,
                                               input logic wr_lo, input logic wr_hi,
                                               input logic [31:0] wdata);
        logic [31:0] lo;
        logic [31:0] hi;
        logic        carry;
        carry = inc & ~wr_lo & (cur[31:0] == 32'hFFFF_FFFF);
        lo    = wr_lo ? wdata : cur[31:0] + {31'b0, inc};
        hi    = wr_hi ? wdata : cur[63:32] + {31'b0, carry};
        return {hi, lo};
    endfunction

    // Selector k counts events[k-1]; 0 and anything past NUM_EVENTS count nothing.
    function automatic logic event_hit(input logic [7:0] sel,
                                       input logic [NUM_EVENTS-1:0] ev);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_EVENTS; k++) begin
            if (sel == 8'(k + 1)) hit = ev[k];
        end
        return hit;
    endfunction

    // Half of counter n (0/1 cycle, 2 instret, 3.. HPM); unimplemented read 0.
    function automatic logic [31:0] counter_half(input logic [4:0] n, input logic hi);
        logic [63:0] c;
        c = '0;
        if (n == 5'd0 || n == 5'd1) begin
            c = cycle_q;
        end else if (n == 5'd2) begin
            c = instret_q;
        end else begin
            for (int i = 0; i < NUM_HPM; i++) begin
                if (n == 5'(i + 3)) c = hpm_q[i];
            end
        end
        return hi ? c[63:32] : c[31:0];
    endfunction

    // Event selector n; unimplemented selectors read 0.
    function automatic logic [31:0] selector_read(input logic [4:0] n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < NUM_HPM; i++) begin
            if (n == 5'(i + 3)) v = {24'b0, sel_q[i]};
        end
        return v;
    endfunction

    // Combinational read port and address decode.
    always_comb begin
        read_data = '0;
        readable  = 1'b0;
        writeable = 1'b0;
        case (read_address) inside
            12'h300: begin
                readable  = 1'b1;
                writeable = 1'b1;
                read_data = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
            end
            12'h301: begin
                readable  = 1'b1;
                writeable = 1'b1;
                read_data = 32'h4000_0100;
            end
            12'h304: begin
                readable  = 1'b1;
                writeable = 1'b1;
                read_data = {20'b0, meie_q, 3'b0, mtie_q, 3'b0, msie_q, 3'b0};
            end
            12'h305: begin
                readable  = 1'b1;
                writeable = 1'b1;
                read_data = {mtvec_q, 2'b00};
            end
            12'h320: begin
                readable  = 1'b1;
                writeable = 1'b1;
                read_data = inhibit_q;
            end
            [12'h323:12'h33F]: begin
                readable  = 1'b1;
                writeable = 1'b1;
                read_data = selector_read(read_address[4:0]);
            end
            12'h340: begin
                readable  = 1'b1;
                writeable = 1'b1;
                read_data = mscratch_q;
            end
            12'h341: begin
                readable  = 1'b1;
                writeable = 1'b1;
                read_data = {mepc_q, 2'b00};
            end
            12'h342: begin
                readable  = 1'b1;
                writeable = 1'b1;
                read_data = {mcause_int_q, 27'b0, mcause_code_q};
            end
            12'h343: begin
                readable  = 1'b1;
                writeable = 1'b1;
            end
            12'h344: begin
                readable  = 1'b1;
                writeable = 1'b1;
                read_data = {20'b0, meip_q, 3'b0, mtip_q, 3'b0, msip_q, 3'b0};
            end
            [12'hB00:12'hB1F], [12'hB80:12'hB9F]: begin
                readable  = 1'b1;
                writeable = 1'b1;
                read_data = counter_half(read_address[4:0], read_address[7]);
            end
            [12'hC00:12'hC1F], [12'hC80:12'hC9F]: begin
                readable  = 1'b1;
                read_data = counter_half(read_address[4:0], read_address[7]);
            end
            [12'hF11:12'hF14]: begin
                readable  = 1'b1;
            end
            default: ;
        endcase
    end

    // Next state for CSR fields: CSR write first, then trap/mret override it.
    always_comb begin
        mie_d         = mie_q;
        mpie_d        = mpie_q;
        meie_d        = meie_q;
        mtie_d        = mtie_q;
        msie_d        = msie_q;
        mtvec_d       = mtvec_q;
        mscratch_d    = mscratch_q;
        mepc_d        = mepc_q;
        mcause_int_d  = mcause_int_q;
        mcause_code_d = mcause_code_q;
        inhibit_d     = inhibit_q;
        for (int i = 0; i < HpmSlots; i++) sel_d[i] = sel_q[i];

        if (write_enable) begin
            case (write_address)
                12'h300: begin
                    mie_d  = write_data[3];
                    mpie_d = write_data[7];
                end
                12'h304: begin
                    meie_d = write_data[11];
                    mtie_d = write_data[7];
                    msie_d = write_data[3];
                end
                12'h305: mtvec_d = write_data[31:2];
                12'h320: inhibit_d = write_data & InhibitMask;
                12'h340: mscratch_d = write_data;
                12'h341: mepc_d = write_data[31:2];
                12'h342: begin
                    mcause_int_d  = write_data[31];
                    mcause_code_d = write_data[3:0];
                end
                default: ;
            endcase
            for (int i = 0; i < NUM_HPM; i++) begin
                if (write_address == 12'(32'h323 + i)) sel_d[i] = write_data[7:0];
            end
        end

        if (traped) begin
            mpie_d        = mie_q;
            mie_d         = 1'b0;
            mepc_d        = ecp[31:2];
            mcause_int_d  = interupt;
            mcause_code_d = trap_cause;
        end else if (mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
    end

    // Next state for all 64-bit counters, gated by the registered inhibit bits.
    always_comb begin
        cycle_d = count_next(cycle_q, ~inhibit_q[0],
                             write_enable && (write_address == 12'hB00 ||
                                              write_address == 12'hB01),
                             write_enable && (write_address == 12'hB80 ||
                                              write_address == 12'hB81),
                             write_data);
        instret_d = count_next(instret_q, retired & ~inhibit_q[2],
                               write_enable && write_address == 12'hB02,
                               write_enable && write_address == 12'hB82,
                               write_data);
        for (int i = 0; i < HpmSlots; i++) hpm_d[i] = hpm_q[i];
        for (int i = 0; i < NUM_HPM; i++) begin
            hpm_d[i] = count_next(hpm_q[i],
                                  ~inhibit_q[3 + i] & event_hit(sel_q[i], events),
                                  write_enable && write_address == 12'(32'hB03 + i),
                                  write_enable && write_address == 12'(32'hB83 + i),
                                  write_data);
        end
    end

    // CSR and counter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q         <= 1'b0;
            mpie_q        <= 1'b0;
            meie_q        <= 1'b0;
            mtie_q        <= 1'b0;
            msie_q        <= 1'b0;
            mtvec_q       <= MTVEC_RESET[31:2];
            mscratch_q    <= '0;
            mepc_q        <= '0;
            mcause_int_q  <= 1'b0;
            mcause_code_q <= '0;
            inhibit_q     <= '0;
            cycle_q       <= '0;
            instret_q     <= '0;
            for (int i = 0; i < HpmSlots; i++) begin
                hpm_q[i] <= '0;
                sel_q[i] <= '0;
            end
        end else begin
            mie_q         <= mie_d;
            mpie_q        <= mpie_d;
            meie_q        <= meie_d;
            mtie_q        <= mtie_d;
            msie_q        <= msie_d;
            mtvec_q       <= mtvec_d;
            mscratch_q    <= mscratch_d;
            mepc_q        <= mepc_d;
            mcause_int_q  <= mcause_int_d;
            mcause_code_q <= mcause_code_d;
            inhibit_q     <= inhibit_d;
            cycle_q       <= cycle_d;
            instret_q     <= instret_d;
            for (int i = 0; i < HpmSlots; i++) begin
                hpm_q[i] <= hpm_d[i];
                sel_q[i] <= sel_d[i];
            end
        end
    end

    // Single-stage capture of the level-sensitive interrupt lines into mip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meip_q <= 1'b0;
            mtip_q <= 1'b0;
            msip_q <= 1'b0;
        end else begin
            meip_q <= ext_irq;
            mtip_q <= timer_irq;
            msip_q <= soft_irq;
        end
    end

    assign eip         = mie_q & meie_q & meip_q;
    assign tip         = mie_q & mtie_q & mtip_q;
    assign sip         = mie_q & msie_q & msip_q;
    assign trap_vector = {mtvec_q, 2'b00};
    assign mret_vector = {mepc_q, 2'b00};

endmodule

// File: tb/tb_csr_hpm.sv
// tb_csr_hpm: scenario tasks with randomized stimulus against a behavioural model.
module tb_csr_hpm;

    localparam int unsigned NumHpm     = 4;
    localparam int unsigned NumEvents  = 8;
    localparam logic [31:0] MtvecReset = 32'h0000_1000;
    localparam logic [31:0] InhMask    = 32'h0000_007D;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [11:0]          read_address;
    logic [31:0]          read_data;
    logic                 readable, writeable;
    logic                 write_enable;
    logic [11:0]          write_address;
    logic [31:0]          write_data;
    logic                 retired, traped, mret, interupt;
    logic [31:0]          ecp;
    logic [3:0]           trap_cause;
    logic                 ext_irq, timer_irq, soft_irq;
    logic [NumEvents-1:0] events;
    logic                 eip, tip, sip;
    logic [31:0]          trap_vector, mret_vector;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rdata;
    logic        rd_r, rd_w;

    csr_hpm #(
        .NUM_HPM    (NumHpm),
        .NUM_EVENTS (NumEvents),
        .MTVEC_RESET(MtvecReset)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .read_address (read_address),
        .read_data    (read_data),
        .readable     (readable),
        .writeable    (writeable),
        .write_enable (write_enable),
        .write_address(write_address),
        .write_data   (write_data),
        .retired      (retired),
        .traped       (traped),
        .mret         (mret),
        .ecp          (ecp),
        .trap_cause   (trap_cause),
        .interupt     (interupt),
        .ext_irq      (ext_irq),
        .timer_irq    (timer_irq),
        .soft_irq     (soft_irq),
        .events       (events),
        .eip          (eip),
        .tip          (tip),
        .sip          (sip),
        .trap_vector  (trap_vector),
        .mret_vector  (mret_vector)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a);
        read_address = a;
        #1;
        rdata = read_data;
        rd_r  = readable;
        rd_w  = writeable;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        write_enable  = 1'b1;
        write_address = a;
        write_data    = d;
        tick();
        write_enable  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if ({eip, tip, sip} !== 3'b000) begin errors++;
            $display("FAIL reset_irq: got %b want 000", {eip, tip, sip}); end
        checks++; if (trap_vector !== MtvecReset) begin errors++;
            $display("FAIL reset_trap_vector: got %h want %h", trap_vector, MtvecReset); end
        checks++; if (mret_vector !== 32'h0) begin errors++;
            $display("FAIL reset_mret_vector: got %h want 0", mret_vector); end
        rd(12'h301);
        checks++; if (rdata !== 32'h4000_0100) begin errors++;
            $display("FAIL misa: got %h want 40000100", rdata); end
        rd(12'h7C0);
        checks++; if ({rd_r, rd_w, rdata} !== 34'h0) begin errors++;
            $display("FAIL unmapped_7c0: got r=%b w=%b d=%h want 0 0 0", rd_r, rd_w, rdata); end
        rd(12'hC00);
        checks++; if ({rd_r, rd_w} !== 2'b10) begin errors++;
            $display("FAIL user_mirror_ro: got r=%b w=%b want 1 0", rd_r, rd_w); end
        rd(12'hF14);
        checks++; if ({rd_r, rd_w, rdata} !== {2'b10, 32'h0}) begin errors++;
            $display("FAIL mhartid: got r=%b w=%b d=%h want 1 0 0", rd_r, rd_w, rdata); end
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        rd(12'hB00);
        checks++; if (rdata !== 32'd10) begin errors++;
            $display("FAIL mcycle_after_10: got %0d want 10", rdata); end
        rd(12'hB02);
        checks++; if (rdata !== 32'd0) begin errors++;
            $display("FAIL minstret_idle: got %0d want 0", rdata); end
    endtask

    task automatic test_minstret();
        int unsigned cnt;
        wr(12'hB02, 32'h0);
        wr(12'hB82, 32'h0);
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            retired = 1'($urandom);
            if (retired) cnt++;
            tick();
        end
        retired = 1'b0;
        rd(12'hB02);
        checks++; if (rdata !== cnt) begin errors++;
            $display("FAIL minstret_count: got %0d want %0d", rdata, cnt); end
        rd(12'hC02);
        checks++; if (rdata !== cnt) begin errors++;
            $display("FAIL instret_mirror: got %0d want %0d", rdata, cnt); end
        wr(12'h320, 32'h4);
        retired = 1'b1;
        repeat (5) tick();
        retired = 1'b0;
        rd(12'hB02);
        checks++; if (rdata !== cnt) begin errors++;
            $display("FAIL minstret_inhibit: got %0d want %0d", rdata, cnt); end
        wr(12'h320, 32'h0);
    endtask

    task automatic test_carry();
        longint unsigned exp;
        logic [31:0]     hi, lo;
        int              k;
        wr(12'hB00, 32'hFFFF_FFFE);
        wr(12'hB80, 32'h5);
        tick();
        rd(12'hB00);
        checks++; if (rdata !== 32'h0) begin errors++;
            $display("FAIL carry_lo: got %h want 0", rdata); end
        rd(12'hB80);
        checks++; if (rdata !== 32'h6) begin errors++;
            $display("FAIL carry_hi: got %h want 6", rdata); end
        wr(12'hB80, 32'h7);
        wr(12'hB00, 32'hFFFF_FFFF);
        wr(12'hB00, 32'h123);
        rd(12'hB00);
        checks++; if (rdata !== 32'h123) begin errors++;
            $display("FAIL lo_write_wrap_lo: got %h want 123", rdata); end
        rd(12'hB80);
        checks++; if (rdata !== 32'h7) begin errors++;
            $display("FAIL lo_write_no_carry: got %h want 7", rdata); end
        for (int it = 0; it < 5; it++) begin
            hi = $urandom;
            lo = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            k  = $urandom_range(1, 6);
            wr(12'hB80, hi);
            wr(12'hB00, lo);
            repeat (k) tick();
            exp = {hi, lo} + 64'(k);
            rd(12'hB00);
            checks++; if (rdata !== exp[31:0]) begin errors++;
                $display("FAIL rand_carry_lo: got %h want %h", rdata, exp[31:0]); end
            rd(12'hC80);
            checks++; if (rdata !== exp[63:32]) begin errors++;
                $display("FAIL rand_carry_hi: got %h want %h", rdata, exp[63:32]); end
        end
    endtask

    task automatic test_hpm_events();
        events = '0;
        wr(12'h323, 32'h2);
        wr(12'hB03, 32'h0);
        wr(12'hB83, 32'h0);
        repeat (7) begin
            events = 8'b0000_0010;
            tick();
            events = '0;
            tick();
        end
        rd(12'hB03);
        checks++; if (rdata !== 32'd7) begin errors++;
            $display("FAIL hpm3_seven: got %0d want 7", rdata); end
        wr(12'h320, 32'h8);
        repeat (3) begin
            events = 8'b0000_0010;
            tick();
            events = '0;
            tick();
        end
        rd(12'hB03);
        checks++; if (rdata !== 32'd7) begin errors++;
            $display("FAIL hpm3_frozen: got %0d want 7", rdata); end
        wr(12'h320, 32'hFFFF_FFFF);
        rd(12'h320);
        checks++; if (rdata !== InhMask) begin errors++;
            $display("FAIL inhibit_mask: got %h want %h", rdata, InhMask); end
        wr(12'h320, 32'h0);
        wr(12'h323, 32'h9);
        wr(12'hB03, 32'h0);
        rd(12'h323);
        checks++; if (rdata !== 32'h9) begin errors++;
            $display("FAIL sel_readback: got %h want 9", rdata); end
        events = '1;
        repeat (5) tick();
        events = '0;
        rd(12'hB03);
        checks++; if (rdata !== 32'd0) begin errors++;
            $display("FAIL hpm3_sel_out_of_range: got %0d want 0", rdata); end
    endtask

    task automatic test_hpm_random();
        longint unsigned model [NumHpm];
        logic [7:0]      sel   [NumHpm];
        logic [31:0]     inh, wval;
        logic            do_w;
        int              idx;
        events = '0;
        for (int i = 0; i < NumHpm; i++) begin
            sel[i] = (i == 0) ? 8'($urandom_range(1, NumEvents)) : 8'($urandom_range(0, 10));
            wr(12'(32'h323 + i), {24'b0, sel[i]});
            wr(12'(32'hB03 + i), 32'h0);
            wr(12'(32'hB83 + i), 32'h0);
            model[i] = 0;
        end
        wr(12'hB03, 32'hFFFF_FFF0);
        model[0] = 64'hFFFF_FFF0;
        inh = 32'h0;
        for (int c = 0; c < 300; c++) begin
            events = NumEvents'($urandom);
            do_w   = ($urandom_range(0, 15) == 0);
            wval   = $urandom;
            for (int i = 0; i < NumHpm; i++) begin
                idx = int'(sel[i]) - 1;
                if (!inh[3 + i] && sel[i] >= 1 && sel[i] <= NumEvents && events[idx])
                    model[i]++;
            end
            if (do_w) begin
                write_enable  = 1'b1;
                write_address = 12'h320;
                write_data    = wval;
            end
            tick();
            write_enable = 1'b0;
            if (do_w) inh = wval & InhMask;
        end
        events = '0;
        for (int i = 0; i < NumHpm; i++) begin
            rd(12'(32'hB03 + i));
            checks++; if (rdata !== model[i][31:0]) begin errors++;
                $display("FAIL hpm_rand_lo[%0d]: got %h want %h", i, rdata, model[i][31:0]); end
            rd(12'(32'hB83 + i));
            checks++; if (rdata !== model[i][63:32]) begin errors++;
                $display("FAIL hpm_rand_hi[%0d]: got %h want %h", i, rdata, model[i][63:32]); end
        end
        wr(12'h320, 32'h0);
    endtask

    task automatic test_interrupts();
        logic       e, t, s, m;
        logic [2:0] en;
        wr(12'h300, 32'h8);
        wr(12'h304, 32'h80);
        timer_irq = 1'b1;
        #1;
        checks++; if (tip !== 1'b0) begin errors++;
            $display("FAIL tip_early: got %b want 0", tip); end
        tick();
        checks++; if (tip !== 1'b1) begin errors++;
            $display("FAIL tip_one_cycle: got %b want 1", tip); end
        rd(12'h344);
        checks++; if (rdata !== 32'h80) begin errors++;
            $display("FAIL mip_timer: got %h want 80", rdata); end
        wr(12'h344, 32'h0);
        rd(12'h344);
        checks++; if (rdata !== 32'h80) begin errors++;
            $display("FAIL mip_write_ignored: got %h want 80", rdata); end
        for (int it = 0; it < 12; it++) begin
            {e, t, s} = 3'($urandom);
            en        = 3'($urandom);
            m         = 1'($urandom);
            ext_irq   = e;
            timer_irq = t;
            soft_irq  = s;
            wr(12'h304, (32'(en[2]) << 11) | (32'(en[1]) << 7) | (32'(en[0]) << 3));
            wr(12'h300, 32'(m) << 3);
            checks++; if ({eip, tip, sip} !== {m & en[2] & e, m & en[1] & t, m & en[0] & s})
            begin errors++;
                $display("FAIL irq_rand: got %b want %b", {eip, tip, sip},
                         {m & en[2] & e, m & en[1] & t, m & en[0] & s}); end
            rd(12'h344);
            checks++; if (rdata !== ((32'(e) << 11) | (32'(t) << 7) | (32'(s) << 3))) begin
                errors++;
                $display("FAIL mip_rand: got %h want %h", rdata,
                         (32'(e) << 11) | (32'(t) << 7) | (32'(s) << 3)); end
            rd(12'h300);
            checks++; if (rdata !== (32'h1800 | (32'(m) << 3))) begin errors++;
                $display("FAIL mstatus_rand: got %h want %h", rdata, 32'h1800 | (32'(m) << 3));
            end
        end
        {ext_irq, timer_irq, soft_irq} = 3'b000;
        wr(12'h300, 32'h0);
        wr(12'h304, 32'h0);
    endtask

    task automatic test_trap();
        logic [31:0] pc;
        wr(12'h305, 32'h8000_0103);
        rd(12'h305);
        checks++; if (rdata !== 32'h8000_0100 || trap_vector !== 32'h8000_0100) begin errors++;
            $display("FAIL mtvec: got %h/%h want 80000100", rdata, trap_vector); end
        wr(12'h300, 32'h8);
        traped = 1'b1; ecp = 32'h104; trap_cause = 4'd7; interupt = 1'b1;
        tick();
        traped = 1'b0; interupt = 1'b0;
        rd(12'h341);
        checks++; if (rdata !== 32'h104) begin errors++;
            $display("FAIL trap_mepc: got %h want 104", rdata); end
        rd(12'h342);
        checks++; if (rdata !== 32'h8000_0007) begin errors++;
            $display("FAIL trap_mcause: got %h want 80000007", rdata); end
        rd(12'h300);
        checks++; if (rdata !== 32'h1880) begin errors++;
            $display("FAIL trap_mstatus: got %h want 1880", rdata); end
        mret = 1'b1;
        tick();
        mret = 1'b0;
        rd(12'h300);
        checks++; if (rdata !== 32'h1888) begin errors++;
            $display("FAIL mret_mstatus: got %h want 1888", rdata); end
        checks++; if (mret_vector !== 32'h104) begin errors++;
            $display("FAIL mret_vector: got %h want 104", mret_vector); end
        for (int it = 0; it < 4; it++) begin
            pc = $urandom;
            traped = 1'b1; ecp = pc; trap_cause = 4'($urandom); interupt = 1'b0;
            tick();
            traped = 1'b0;
            checks++; if (mret_vector !== (pc & 32'hFFFF_FFFC)) begin errors++;
                $display("FAIL rand_mepc: got %h want %h", mret_vector, pc & 32'hFFFF_FFFC); end
        end
    endtask

    task automatic test_simultaneous();
        wr(12'h300, 32'h8);
        traped = 1'b1; mret = 1'b1; ecp = 32'h200; trap_cause = 4'd3; interupt = 1'b0;
        write_enable = 1'b1; write_address = 12'h300; write_data = 32'h0;
        tick();
        traped = 1'b0; mret = 1'b0; write_enable = 1'b0;
        rd(12'h300);
        checks++; if (rdata !== 32'h1880) begin errors++;
            $display("FAIL simul_mstatus: got %h want 1880", rdata); end
        rd(12'h342);
        checks++; if (rdata !== 32'h3) begin errors++;
            $display("FAIL simul_mcause: got %h want 3", rdata); end
        mret = 1'b1;
        write_enable = 1'b1; write_address = 12'h300; write_data = 32'h0;
        tick();
        mret = 1'b0; write_enable = 1'b0;
        rd(12'h300);
        checks++; if (rdata !== 32'h1888) begin errors++;
            $display("FAIL mret_beats_write: got %h want 1888", rdata); end
        traped = 1'b1; ecp = 32'h300;
        write_enable = 1'b1; write_address = 12'h341; write_data = 32'h444;
        tick();
        traped = 1'b0; write_enable = 1'b0;
        rd(12'h341);
        checks++; if (rdata !== 32'h300) begin errors++;
            $display("FAIL trap_beats_mepc_write: got %h want 300", rdata); end
    endtask

    task automatic test_random_rw();
        logic [11:0] addrs [16];
        logic [11:0] a;
        logic [31:0] d, exp;
        addrs = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                  12'h344, 12'h323, 12'h326, 12'h327, 12'h33F, 12'hB07, 12'hB87, 12'hB1F};
        for (int it = 0; it < 40; it++) begin
            a = addrs[$urandom_range(0, 15)];
            d = $urandom;
            wr(a, d);
            case (a)
                12'h300: exp = (d & 32'h88) | 32'h1800;
                12'h301: exp = 32'h4000_0100;
                12'h304: exp = d & 32'h888;
                12'h305, 12'h341: exp = d & 32'hFFFF_FFFC;
                12'h340: exp = d;
                12'h342: exp = d & 32'h8000_000F;
                12'h323, 12'h326: exp = d & 32'hFF;
                default: exp = 32'h0;
            endcase
            rd(a);
            checks++; if ({rd_r, rd_w, rdata} !== {2'b11, exp}) begin errors++;
                $display("FAIL rw_%h: got r=%b w=%b d=%h want 1 1 %h", a, rd_r, rd_w, rdata, exp);
            end
        end
        wr(12'h300, 32'h0);
    endtask

    task automatic test_midrun_reset();
        retired = 1'b1;
        events  = '1;
        repeat (6) tick();
        retired = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        rd(12'hB00);
        checks++; if (rdata !== 32'h0) begin errors++;
            $display("FAIL async_rst_mcycle: got %h want 0", rdata); end
        rd(12'hB02);
        checks++; if (rdata !== 32'h0) begin errors++;
            $display("FAIL async_rst_minstret: got %h want 0", rdata); end
        rd(12'hB03);
        checks++; if (rdata !== 32'h0) begin errors++;
            $display("FAIL async_rst_hpm3: got %h want 0", rdata); end
        checks++; if (trap_vector !== MtvecReset) begin errors++;
            $display("FAIL async_rst_mtvec: got %h want %h", trap_vector, MtvecReset); end
        events = '0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        rd(12'hB00);
        checks++; if (rdata !== 32'd3) begin errors++;
            $display("FAIL resume_mcycle: got %0d want 3", rdata); end
    endtask

    initial begin
        rst_n = 1'b0;
        read_address = '0; write_enable = 1'b0; write_address = '0; write_data = '0;
        retired = 1'b0; traped = 1'b0; mret = 1'b0; ecp = '0; trap_cause = '0;
        interupt = 1'b0; ext_irq = 1'b0; timer_irq = 1'b0; soft_irq = 1'b0; events = '0;
        test_reset();
        test_minstret();
        test_carry();
        test_hpm_events();
        test_hpm_random();
        test_interrupts();
        test_trap();
        test_simultaneous();
        test_random_rw();
        test_midrun_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
